msrh_l2_req_arbiter: RTL and testbench



---
 rtl/msrh_l2_req_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_msrh_l2_req_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msrh_l2_req_arbiter.sv
// Round-robin arbiter merging ICache/DCache/PTW requests into one L2 request port,
// with per-requester outstanding credit tracking and tag-based response routing.
module msrh_l2_req_arbiter #(
  parameter int unsigned REQ_NUM   = 3,
  parameter int unsigned PADDR_W   = 56,
  parameter int unsigned DATA_W    = 512,
  parameter int unsigned CMD_W     = 5,
  parameter int unsigned SUB_TAG_W = 4,
  parameter int unsigned MAX_OUTS  = 4
) (
  input  logic                            i_clk,
  input  logic                            i_reset,

  input  logic [REQ_NUM-1:0]              i_req_valid,
  output logic [REQ_NUM-1:0]              o_req_ready,
  input  logic [REQ_NUM*CMD_W-1:0]        i_req_cmd,
  input  logic [REQ_NUM*PADDR_W-1:0]      i_req_addr,
  input  logic [REQ_NUM*DATA_W-1:0]       i_req_data,
  input  logic [REQ_NUM*(DATA_W/8)-1:0]   i_req_be,
  input  logic [REQ_NUM*SUB_TAG_W-1:0]    i_req_tag,

  output logic                            o_l2_req_valid,
  input  logic                            i_l2_req_ready,
  output logic [CMD_W-1:0]                o_l2_req_cmd,
  output logic [PADDR_W-1:0]              o_l2_req_addr,
  output logic [DATA_W-1:0]               o_l2_req_data,
  output logic [DATA_W/8-1:0]             o_l2_req_be,
  output logic [2+SUB_TAG_W-1:0]          o_l2_req_tag,

  input  logic                            i_l2_resp_valid,
  input  logic [2+SUB_TAG_W-1:0]          i_l2_resp_tag,
  input  logic [DATA_W-1:0]               i_l2_resp_data,
  output logic                            o_l2_resp_ready,

  output logic [REQ_NUM-1:0]              o_resp_valid,
  output logic [SUB_TAG_W-1:0]            o_resp_tag,
  output logic [DATA_W-1:0]               o_resp_data,

  output logic                            o_err_unexp_resp
);

  localparam int unsigned ID_W  = 2;
  localparam int unsigned TAG_W = ID_W + SUB_TAG_W;
  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = $clog2(MAX_OUTS + 1);

  typedef enum logic {
    ST_EMPTY,
    ST_HOLD
  } state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    rr_q, rr_d;
  logic [CNT_W-1:0]   cnt_q [REQ_NUM];
  logic [CNT_W-1:0]   cnt_d [REQ_NUM];
  logic               err_q, err_d;

  logic [CMD_W-1:0]   cmd_q;
  logic [PADDR_W-1:0] addr_q;
  logic [DATA_W-1:0]  data_q;
  logic [BE_W-1:0]    be_q;
  logic [TAG_W-1:0]   tag_q;

  logic [CMD_W-1:0]     sel_cmd;
  logic [PADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]    sel_data;
  logic [BE_W-1:0]      sel_be;
  logic [SUB_TAG_W-1:0] sel_tag;

  logic [REQ_NUM-1:0] elig;
  logic               grant_vld;
  logic [ID_W-1:0]    grant_idx;
  logic               slot_free;
  logic               grant_fire;
  logic [ID_W-1:0]    resp_id;
  logic               resp_unexp;

  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      elig[i] = i_req_valid[i] && (cnt_q[i] < CNT_W'(MAX_OUTS));
    end
  end

  // Scan requesters in order rr_q, rr_q+1, ... and take the first eligible one.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < REQ_NUM; k++) begin
      for (int unsigned i = 0; i < REQ_NUM; i++) begin
        if (!grant_vld && elig[i] && (i == (32'(rr_q) + k) % REQ_NUM)) begin
          grant_vld = 1'b1;
          grant_idx = ID_W'(i);
        end
      end
    end
  end

  assign slot_free  = (state_q == ST_EMPTY) || i_l2_req_ready;
  assign grant_fire = grant_vld && slot_free && !i_reset;

  always_comb begin
    o_req_ready = '0;
    sel_cmd     = '0;
    sel_addr    = '0;
    sel_data    = '0;
    sel_be      = '0;
    sel_tag     = '0;
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      if (grant_idx == ID_W'(i)) begin
        o_req_ready[i] = grant_fire;
        sel_cmd        = i_req_cmd [i*CMD_W     +: CMD_W];
        sel_addr       = i_req_addr[i*PADDR_W   +: PADDR_W];
        sel_data       = i_req_data[i*DATA_W    +: DATA_W];
        sel_be         = i_req_be  [i*BE_W      +: BE_W];
        sel_tag        = i_req_tag [i*SUB_TAG_W +: SUB_TAG_W];
      end
    end
  end

  // Responses route only to a requester that actually has something outstanding.
  assign resp_id = i_l2_resp_tag[TAG_W-1 -: ID_W];

  always_comb begin
    o_resp_valid = '0;
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      if ((resp_id == ID_W'(i)) && (cnt_q[i] != '0) && !i_reset) begin
        o_resp_valid[i] = i_l2_resp_valid;
      end
    end
  end

  assign resp_unexp      = i_l2_resp_valid && (o_resp_valid == '0);
  assign o_resp_tag      = i_l2_resp_tag[SUB_TAG_W-1:0];
  assign o_resp_data     = i_l2_resp_data;
  assign o_l2_resp_ready = 1'b1;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    err_d   = err_q | resp_unexp;
    if (grant_fire) begin
      state_d = ST_HOLD;
      rr_d    = ID_W'((32'(grant_idx) + 1) % REQ_NUM);
    end else if ((state_q == ST_HOLD) && i_l2_req_ready) begin
      state_d = ST_EMPTY;
    end
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      cnt_d[i] = cnt_q[i];
      if (o_req_ready[i] && !o_resp_valid[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (!o_req_ready[i] && o_resp_valid[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_EMPTY;
      rr_q    <= '0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < REQ_NUM; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
      for (int unsigned i = 0; i < REQ_NUM; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Payload is only observable while HOLD, so it needs no reset.
  always_ff @(posedge i_clk) begin
    if (grant_fire) begin
      cmd_q  <= sel_cmd;
      addr_q <= sel_addr;
      data_q <= sel_data;
      be_q   <= sel_be;
      tag_q  <= {grant_idx, sel_tag};
    end
  end

  assign o_l2_req_valid   = (state_q == ST_HOLD);
  assign o_l2_req_cmd     = cmd_q;
  assign o_l2_req_addr    = addr_q;
  assign o_l2_req_data    = data_q;
  assign o_l2_req_be      = be_q;
  assign o_l2_req_tag     = tag_q;
  assign o_err_unexp_resp = err_q;

endmodule

// File: tb/tb_msrh_l2_req_arbiter.sv
// Directed bench for msrh_l2_req_arbiter: issue order, stalls, credits and response routing,
// with issued L2 requests checked against a scoreboard queue.
module tb_msrh_l2_req_arbiter;

  localparam int unsigned REQ_NUM   = 3;
  localparam int unsigned PADDR_W   = 56;
  localparam int unsigned DATA_W    = 512;
  localparam int unsigned CMD_W     = 5;
  localparam int unsigned SUB_TAG_W = 4;
  localparam int unsigned MAX_OUTS  = 4;
  localparam int unsigned TAG_W     = 2 + SUB_TAG_W;
  localparam int unsigned BE_W      = DATA_W / 8;

  logic                          i_clk = 1'b0;
  logic                          i_reset;
  logic [REQ_NUM-1:0]            i_req_valid;
  logic [REQ_NUM-1:0]            o_req_ready;
  logic [REQ_NUM*CMD_W-1:0]      i_req_cmd;
  logic [REQ_NUM*PADDR_W-1:0]    i_req_addr;
  logic [REQ_NUM*DATA_W-1:0]     i_req_data;
  logic [REQ_NUM*BE_W-1:0]       i_req_be;
  logic [REQ_NUM*SUB_TAG_W-1:0]  i_req_tag;
  logic                          o_l2_req_valid;
  logic                          i_l2_req_ready;
  logic [CMD_W-1:0]              o_l2_req_cmd;
  logic [PADDR_W-1:0]            o_l2_req_addr;
  logic [DATA_W-1:0]             o_l2_req_data;
  logic [BE_W-1:0]               o_l2_req_be;
  logic [TAG_W-1:0]              o_l2_req_tag;
  logic                          i_l2_resp_valid;
  logic [TAG_W-1:0]              i_l2_resp_tag;
  logic [DATA_W-1:0]             i_l2_resp_data;
  logic                          o_l2_resp_ready;
  logic [REQ_NUM-1:0]            o_resp_valid;
  logic [SUB_TAG_W-1:0]          o_resp_tag;
  logic [DATA_W-1:0]             o_resp_data;
  logic                          o_err_unexp_resp;

  msrh_l2_req_arbiter #(
    .REQ_NUM  (REQ_NUM),
    .PADDR_W  (PADDR_W),
    .DATA_W   (DATA_W),
    .CMD_W    (CMD_W),
    .SUB_TAG_W(SUB_TAG_W),
    .MAX_OUTS (MAX_OUTS)
  ) dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_req_valid     (i_req_valid),
    .o_req_ready     (o_req_ready),
    .i_req_cmd       (i_req_cmd),
    .i_req_addr      (i_req_addr),
    .i_req_data      (i_req_data),
    .i_req_be        (i_req_be),
    .i_req_tag       (i_req_tag),
    .o_l2_req_valid  (o_l2_req_valid),
    .i_l2_req_ready  (i_l2_req_ready),
    .o_l2_req_cmd    (o_l2_req_cmd),
    .o_l2_req_addr   (o_l2_req_addr),
    .o_l2_req_data   (o_l2_req_data),
    .o_l2_req_be     (o_l2_req_be),
    .o_l2_req_tag    (o_l2_req_tag),
    .i_l2_resp_valid (i_l2_resp_valid),
    .i_l2_resp_tag   (i_l2_resp_tag),
    .i_l2_resp_data  (i_l2_resp_data),
    .o_l2_resp_ready (o_l2_resp_ready),
    .o_resp_valid    (o_resp_valid),
    .o_resp_tag      (o_resp_tag),
    .o_resp_data     (o_resp_data),
    .o_err_unexp_resp(o_err_unexp_resp)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [TAG_W-1:0]   tag;
    logic [PADDR_W-1:0] addr;
    logic [CMD_W-1:0]   cmd;
  } exp_t;

  exp_t                 sbq[$];
  int unsigned          n_checks = 0;
  int unsigned          n_fail   = 0;
  logic [31:0]          req_addr [REQ_NUM];
  logic [SUB_TAG_W-1:0] req_tag  [REQ_NUM];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int unsigned i, input logic [31:0] addr, input logic [SUB_TAG_W-1:0] tag);
    req_addr[i] = addr;
    req_tag[i]  = tag;
    i_req_addr[i*PADDR_W +: PADDR_W]     = PADDR_W'(addr);
    i_req_tag [i*SUB_TAG_W +: SUB_TAG_W] = tag;
    i_req_cmd [i*CMD_W +: CMD_W]         = CMD_W'(i + 1);
    i_req_data[i*DATA_W +: DATA_W]       = {8{32'hC0DE_0000 | 32'(i), addr}};
    i_req_be  [i*BE_W +: BE_W]           = '1;
  endtask

  task automatic push(input int unsigned g);
    exp_t e;
    e.tag  = {2'(g), req_tag[g]};
    e.addr = PADDR_W'(req_addr[g]);
    e.cmd  = CMD_W'(g + 1);
    sbq.push_back(e);
  endtask

  // Pops the scoreboard on every L2 handshake, then advances one clock.
  task automatic tick();
    exp_t e;
    if (o_l2_req_valid && i_l2_req_ready) begin
      check("sb_pending", 64'(sbq.size() > 0), 64'd1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("sb_tag",  64'(o_l2_req_tag),  64'(e.tag));
        check("sb_addr", 64'(o_l2_req_addr), 64'(e.addr));
        check("sb_cmd",  64'(o_l2_req_cmd),  64'(e.cmd));
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_reset         = 1'b1;
    i_req_valid     = '0;
    i_l2_req_ready  = 1'b0;
    i_l2_resp_valid = 1'b0;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    #1;
  endtask

  initial begin
    i_reset         = 1'b1;
    i_req_valid     = '1;
    i_l2_req_ready  = 1'b1;
    i_l2_resp_valid = 1'b1;
    i_l2_resp_tag   = {2'd0, 4'd1};
    i_l2_resp_data  = {8{64'hA5A5_0123_4567_89AB}};
    i_req_cmd = '0; i_req_addr = '0; i_req_data = '0; i_req_be = '0; i_req_tag = '0;
    set_req(0, 32'h8000_0040, 4'd3);
    set_req(1, 32'h0000_1000, 4'd5);
    set_req(2, 32'h0000_2000, 4'd9);

    // Reset state, with requests and a response pending on the inputs.
    #1;
    check("rst_req_ready",  64'(o_req_ready),     64'd0);
    check("rst_l2_valid",   64'(o_l2_req_valid),  64'd0);
    check("rst_resp_valid", 64'(o_resp_valid),    64'd0);
    check("rst_err",        64'(o_err_unexp_resp), 64'd0);
    check("resp_ready",     64'(o_l2_resp_ready), 64'd1);
    @(posedge i_clk); #1;
    check("rst_err_held",   64'(o_err_unexp_resp), 64'd0);
    do_reset();

    // Single request from req0, latency 1, then its response.
    i_req_valid = 3'b001; i_l2_req_ready = 1'b1; #1;
    check("single_ready", 64'(o_req_ready),    64'b001);
    check("single_lat0",  64'(o_l2_req_valid), 64'd0);
    push(0);
    tick();
    i_req_valid = '0; #1;
    check("single_valid", 64'(o_l2_req_valid), 64'd1);
    check("single_tag",   64'(o_l2_req_tag),   64'h03);
    check("single_addr",  64'(o_l2_req_addr),  64'h8000_0040);
    check("single_data",  64'(o_l2_req_data[63:0]), {32'hC0DE_0000, 32'h8000_0040});
    tick();
    i_l2_resp_valid = 1'b1; i_l2_resp_tag = {2'd0, 4'd3}; #1;
    check("single_resp_valid", 64'(o_resp_valid), 64'b001);
    check("single_resp_tag",   64'(o_resp_tag),   64'd3);
    check("single_resp_data",  o_resp_data[63:0], 64'hA5A5_0123_4567_89AB);
    tick();
    i_l2_resp_valid = 1'b0; #1;
    check("single_no_err", 64'(o_err_unexp_resp), 64'd0);

    // Fairness: all valid, grants 0,1,2,0,1,2 back to back.
    do_reset();
    i_req_valid = 3'b111; i_l2_req_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("rr_grant", 64'(o_req_ready), 64'(1 << (k % 3)));
      if (k > 0) check("rr_no_idle", 64'(o_l2_req_valid), 64'd1);
      push(k % 3);
      tick();
    end
    i_req_valid = '0; #1;
    tick();

    // Stall: HOLD with L2 not ready for 5 cycles, others contend meanwhile.
    do_reset();
    i_req_valid = 3'b010; i_l2_req_ready = 1'b0; #1;
    check("stall_grant", 64'(o_req_ready), 64'b010);
    push(1);
    tick();
    i_req_valid = 3'b101;
    for (int s = 0; s < 5; s++) begin
      #1;
      check("stall_valid", 64'(o_l2_req_valid), 64'd1);
      check("stall_tag",   64'(o_l2_req_tag),   {58'd0, 2'd1, 4'd5});
      check("stall_addr",  64'(o_l2_req_addr),  64'h1000);
      check("stall_ready", 64'(o_req_ready),    64'b000);
      tick();
    end
    i_l2_req_ready = 1'b1; #1;
    check("stall_b2b_grant", 64'(o_req_ready), 64'b100);
    push(2);
    tick();
    i_req_valid = '0; #1;
    tick();

    // Credit limit on req1, skip to req0, resume after a response.
    do_reset();
    i_req_valid = 3'b010; i_l2_req_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("credit_grant", 64'(o_req_ready), 64'b010);
      push(1);
      tick();
    end
    #1;
    check("credit_block", 64'(o_req_ready), 64'b000);
    tick();
    i_req_valid = 3'b011; #1;
    check("credit_skip", 64'(o_req_ready), 64'b001);
    push(0);
    tick();
    i_req_valid = 3'b010; i_l2_resp_valid = 1'b1; i_l2_resp_tag = {2'd1, 4'd2}; #1;
    check("credit_still_block", 64'(o_req_ready),  64'b000);
    check("credit_resp_valid",  64'(o_resp_valid), 64'b010);
    check("credit_resp_tag",    64'(o_resp_tag),   64'd2);
    tick();
    i_l2_resp_valid = 1'b0; #1;
    check("credit_resume", 64'(o_req_ready), 64'b010);
    push(1);
    tick();
    i_req_valid = '0; #1;
    tick();

    // Grant and response to req2 in the same cycle leave its count unchanged.
    do_reset();
    i_req_valid = 3'b100; i_l2_req_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      check("simul_pre_grant", 64'(o_req_ready), 64'b100);
      push(2);
      tick();
    end
    i_l2_resp_valid = 1'b1; i_l2_resp_tag = {2'd2, 4'd7}; #1;
    check("simul_grant", 64'(o_req_ready),  64'b100);
    check("simul_resp",  64'(o_resp_valid), 64'b100);
    push(2);
    tick();
    i_l2_resp_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      check("simul_post_grant", 64'(o_req_ready), 64'b100);
      push(2);
      tick();
    end
    #1;
    check("simul_at_limit", 64'(o_req_ready), 64'b000);
    tick();
    i_req_valid = '0; #1;
    tick();

    // Response with requester id 3 is unexpected and sticky until reset.
    do_reset();
    i_l2_resp_valid = 1'b1; i_l2_resp_tag = {2'd3, 4'd1}; #1;
    check("unexp_id_resp", 64'(o_resp_valid),     64'b000);
    check("unexp_id_err0", 64'(o_err_unexp_resp), 64'd0);
    tick();
    i_l2_resp_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("unexp_id_sticky", 64'(o_err_unexp_resp), 64'd1);
      tick();
    end
    i_reset = 1'b1; #1;
    check("unexp_rst_clear", 64'(o_err_unexp_resp), 64'd0);
    do_reset();

    // Reset while holding an entry: it is dropped, and its response is unexpected.
    i_req_valid = 3'b001; i_l2_req_ready = 1'b0; #1;
    check("rstmid_grant", 64'(o_req_ready), 64'b001);
    tick();
    i_req_valid = '0; #1;
    check("rstmid_hold", 64'(o_l2_req_valid), 64'd1);
    i_reset = 1'b1; #1;
    check("rstmid_drop", 64'(o_l2_req_valid), 64'd0);
    tick();
    i_reset = 1'b0;
    i_l2_resp_valid = 1'b1; i_l2_resp_tag = {2'd0, 4'd3}; #1;
    check("rstmid_resp", 64'(o_resp_valid), 64'b000);
    tick();
    i_l2_resp_valid = 1'b0; #1;
    check("rstmid_err", 64'(o_err_unexp_resp), 64'd1);
    check("sb_drained", 64'(sbq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
